fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Controller that sequences program_memory_block.
- It drives jmp_loc, pc_mux_sel, stall and stall_pm from pipeline events: branch/jump redirects, load-use hazards, and halt/resume.
- It also issues a flush to the IF/ID register so that wrong-path instructions become bubbles.
- It sits between the execute/hazard logic and the fetch stage. All control outputs are registered (Moore).

Parameters:
- PC_W, 16: width of jmp_loc and branch_target.
- HAZ_CYCLES, 1: stall cycles per load-use hazard. Legal range 1..7.
- FLUSH_CYCLES, 2: bubble cycles after a redirect, including the redirect cycle. Legal range 1..3.
- RESET_VECTOR, 16'h0000: PC loaded on boot.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- branch_req  in  1  taken branch/jump this cycle.
- branch_target  in  PC_W  target address; valid with branch_req.
- hazard_req  in  1  load-use hazard detected.
- halt_req  in  1  level request to freeze fetch.
- resume  in  1  leave HALT.
- jmp_loc  out  PC_W  address presented to program memory.
- pc_mux_sel  out  1  1 = PC loads jmp_loc, 0 = PC+1.
- stall  out  1  freeze PC.
- stall_pm  out  1  freeze program-memory output register.
- flush  out  1  force IF/ID to a bubble.
- redirect_ack  out  1  one-cycle pulse when a redirect is applied.
- busy  out  1  1 whenever state != RUN.

Behaviour:
- States: BOOT, RUN, HSTALL, REDIRECT, FLUSH, HALT. A 3-bit down-counter cnt serves HSTALL and FLUSH.
- reset=0 (immediate, no clock needed): state=BOOT, cnt=0, jmp_loc=RESET_VECTOR, pc_mux_sel=1, flush=1, busy=1, stall=0, stall_pm=0, redirect_ack=0.
- BOOT lasts exactly one clock after reset deasserts, then goes to RUN.
- RUN outputs: all controls 0, busy=0. jmp_loc holds its last value.
- Transitions out of RUN are evaluated at each rising edge, in priority order:
  - branch_req -> REDIRECT. jmp_loc <= branch_target.
  - else hazard_req -> HSTALL. cnt <= HAZ_CYCLES-1.
  - else halt_req -> HALT.
- REDIRECT (exactly 1 cycle): pc_mux_sel=1, flush=1, redirect_ack=1, stall=stall_pm=0.
  - Next state is FLUSH with cnt=FLUSH_CYCLES-2.
  - If FLUSH_CYCLES==1, next state is RUN instead.
- FLUSH: flush=1, pc_mux_sel=0. When cnt reaches 0, go to RUN; otherwise decrement cnt.
- HSTALL: stall=stall_pm=1, flush=0. When cnt reaches 0, go to RUN; otherwise decrement cnt. Total stall length is exactly HAZ_CYCLES cycles.
- HALT: stall=stall_pm=1. Stay until resume=1, then go to RUN.
- Latency: an event sampled at edge N produces its output effect during cycle N+1. The PC holds the new target after edge N+2.
- Boundary and simultaneous-event rules:
  - branch_req in HSTALL or HALT preempts the current state: go to REDIRECT and clear cnt.
  - branch_req in FLUSH or REDIRECT retargets: jmp_loc takes the new value, and the flush count restarts from REDIRECT.
  - hazard_req is ignored in REDIRECT, FLUSH and HALT, because the hazarding instruction is already dead or frozen.
  - hazard_req is also ignored in HSTALL. The count is not extended.
  - halt_req is sampled only in RUN. A halt arriving during another state is taken on the first RUN cycle if still asserted.
  - branch_req and resume together in HALT: branch wins, go to REDIRECT.
  - halt_req and resume together in HALT: resume wins.
  - Reset asserted in any state returns to BOOT asynchronously. No partial flush or stall survives reset.
- Only one of {stall, pc_mux_sel} can be 1 in any state, so the PC never receives conflicting commands.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined:
  - Adds outputs perf_redirects[15:0] and perf_stall_cycles[15:0].
  - perf_redirects increments on each REDIRECT cycle.
  - perf_stall_cycles increments on each cycle with stall=1.
  - Both counters saturate at 16'hFFFF and clear on reset.
- Undefined: the ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Package fetch_seq_pkg holds:
  - the state enum encoding (3 bits);
  - PC_W_DEFAULT;
  - the RESET_VECTOR default;
  - the priority-order constants.
- One natural sub-module: seq_cycle_counter. This is a loadable 3-bit down-counter with a zero flag, shared by HSTALL and FLUSH.
- Perf counters stay inline under the macro.

Test Plan:
- Reset: hold reset=0 for 2 cycles.
  - Required: jmp_loc=16'h0000, pc_mux_sel=1, flush=1, busy=1, with no clock edge needed.
  - After release: one BOOT cycle, then RUN with all controls 0 and busy=0.
- Branch (FLUSH_CYCLES=2): branch_req=1 with target 16'h0040 for one cycle.
  - Next cycle: pc_mux_sel=1, jmp_loc=16'h0040, flush=1, redirect_ack=1.
  - Following cycle: flush=1, pc_mux_sel=0.
  - Then RUN.
- Hazard: a one-cycle hazard_req pulse.
  - With HAZ_CYCLES=1: stall=stall_pm=1 for exactly 1 cycle.
  - With HAZ_CYCLES=3: stall=stall_pm=1 for exactly 3 cycles.
  - A repeated hazard_req pulse during HSTALL must not extend the stall.
- Preemption (HAZ_CYCLES=3): hazard at cycle 0, then branch_req with target 16'h0100 at cycle 1.
  - Required: stall drops at cycle 2, pc_mux_sel=1, jmp_loc=16'h0100.
  - Test also branch_req and hazard_req in the same cycle: REDIRECT is taken and there is no stall.
- Halt: hold halt_req; stall stays 1 indefinitely.
  - resume after 5 cycles: RUN on the next cycle.
  - branch_req and resume in the same cycle: REDIRECT is taken.
- Async reset: drop reset mid-FLUSH.
  - All outputs take their reset values immediately.
  - After release, the BOOT-then-RUN sequence repeats.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// fetch_seq_pkg: shared types for the fetch sequencer slice.
// State encoding, defaults, RUN-state event priority, output decode.
package fetch_seq_pkg;

  localparam int PC_W_DEFAULT = 16;
  localparam logic [15:0] RESET_VECTOR_DEFAULT = 16'h0000;

  typedef enum logic [2:0] {
    BOOT     = 3'd0,
    RUN      = 3'd1,
    HSTALL   = 3'd2,
    REDIRECT = 3'd3,
    FLUSH    = 3'd4,
    HALT     = 3'd5
  } state_e;

  // RUN-state events, highest priority first
  typedef enum logic [1:0] {
    EV_NONE   = 2'd0,
    EV_BRANCH = 2'd1,
    EV_HAZARD = 2'd2,
    EV_HALT   = 2'd3
  } run_ev_e;

  typedef struct packed {
    logic pc_mux_sel;
    logic stall;
    logic stall_pm;
    logic flush;
    logic redirect_ack;
    logic busy;
  } ctrl_t;

  function automatic run_ev_e run_event(
    input logic br,
    input logic hz,
    input logic hl
  );
    if (br) return EV_BRANCH;
    if (hz) return EV_HAZARD;
    if (hl) return EV_HALT;
    return EV_NONE;
  endfunction

  // stall and pc_mux_sel are never set together
  function automatic ctrl_t state_ctrl(input state_e s);
    ctrl_t c;
    c = '0;
    unique case (s)
      BOOT: begin
        c.pc_mux_sel = 1'b1;
        c.flush      = 1'b1;
      end
      REDIRECT: begin
        c.pc_mux_sel   = 1'b1;
        c.flush        = 1'b1;
        c.redirect_ack = 1'b1;
      end
      FLUSH: c.flush = 1'b1;
      HSTALL, HALT: begin
        c.stall    = 1'b1;
        c.stall_pm = 1'b1;
      end
      default: ;
    endcase
    c.busy = (s != RUN);
    return c;
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: pipeline events in, fetch controls out.
// master = sequencer side, slave = pipeline/fetch side.
interface fetch_sequencer_if #(
  parameter int PC_W = fetch_seq_pkg::PC_W_DEFAULT
) ();

  logic            branch_req;
  logic [PC_W-1:0] branch_target;
  logic            hazard_req;
  logic            halt_req;
  logic            resume;

  logic [PC_W-1:0] jmp_loc;
  logic            pc_mux_sel;
  logic            stall;
  logic            stall_pm;
  logic            flush;
  logic            redirect_ack;
  logic            busy;

  modport master (
    input  branch_req, branch_target,
    input  hazard_req, halt_req, resume,
    output jmp_loc, pc_mux_sel,
    output stall, stall_pm, flush,
    output redirect_ack, busy
  );

  modport slave (
    output branch_req, branch_target,
    output hazard_req, halt_req, resume,
    input  jmp_loc, pc_mux_sel,
    input  stall, stall_pm, flush,
    input  redirect_ack, busy
  );

endinterface

// File: rtl/fetch_sequencer_seq_cycle_counter.sv
// seq_cycle_counter: loadable 3-bit down-counter with zero flag.
// Ports: clk, reset (async low), load, load_val, dec, zero.
module seq_cycle_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [2:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [2:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && cnt != 3'd0) begin
      cnt <= cnt - 3'd1;
    end
  end

  assign zero = (cnt == 3'd0);

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: Moore controller for redirect/stall/halt of fetch.
// Ports: clk, reset (async low), bus (fetch_sequencer_if.master);
// with FETCH_PERF_EN defined adds perf_redirects, perf_stall_cycles.
module fetch_sequencer
  import fetch_seq_pkg::*;
#(
  parameter int PC_W         = PC_W_DEFAULT,
  parameter int HAZ_CYCLES   = 1,
  parameter int FLUSH_CYCLES = 2,
  parameter logic [PC_W-1:0] RESET_VECTOR =
    PC_W'(RESET_VECTOR_DEFAULT)
) (
  input  logic clk,
  input  logic reset,
  fetch_sequencer_if.master bus
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0] perf_redirects,
  output logic [15:0] perf_stall_cycles
`endif
);

  localparam logic [2:0] HAZ_LOAD =
    3'(HAZ_CYCLES - 1);
  // REDIRECT already counts as the first bubble
  localparam logic [2:0] FLUSH_LOAD =
    3'(FLUSH_CYCLES > 1 ? FLUSH_CYCLES - 2 : 0);

  state_e          state_q, state_d;
  logic [PC_W-1:0] jmp_q, jmp_d;
  ctrl_t           ctrl_q, ctrl_d;
  logic            cnt_load, cnt_dec, cnt_zero;
  logic [2:0]      cnt_val;
  logic            go_red;

  seq_cycle_counter u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    jmp_d    = jmp_q;
    cnt_load = 1'b0;
    cnt_val  = '0;
    cnt_dec  = 1'b0;
    go_red   = 1'b0;
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        unique case (run_event(bus.branch_req,
                               bus.hazard_req,
                               bus.halt_req))
          EV_BRANCH: go_red = 1'b1;
          EV_HAZARD: begin
            state_d  = HSTALL;
            cnt_load = 1'b1;
            cnt_val  = HAZ_LOAD;
          end
          EV_HALT: state_d = HALT;
          default: state_d = RUN;
        endcase
      end
      REDIRECT: begin
        if (bus.branch_req) begin
          go_red = 1'b1;
        end else if (FLUSH_CYCLES == 1) begin
          state_d = RUN;
        end else begin
          state_d  = FLUSH;
          cnt_load = 1'b1;
          cnt_val  = FLUSH_LOAD;
        end
      end
      HSTALL, FLUSH: begin
        if (bus.branch_req) begin
          go_red = 1'b1;
        end else if (cnt_zero) begin
          state_d = RUN;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      HALT: begin
        if (bus.branch_req) begin
          go_red = 1'b1;
        end else if (bus.resume) begin
          state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
    // any taken branch restarts the redirect with a clean count
    if (go_red) begin
      state_d  = REDIRECT;
      jmp_d    = bus.branch_target;
      cnt_load = 1'b1;
      cnt_val  = '0;
    end
    ctrl_d = state_ctrl(state_d);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= BOOT;
      jmp_q   <= RESET_VECTOR;
      ctrl_q  <= state_ctrl(BOOT);
    end else begin
      state_q <= state_d;
      jmp_q   <= jmp_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign bus.jmp_loc      = jmp_q;
  assign bus.pc_mux_sel   = ctrl_q.pc_mux_sel;
  assign bus.stall        = ctrl_q.stall;
  assign bus.stall_pm     = ctrl_q.stall_pm;
  assign bus.flush        = ctrl_q.flush;
  assign bus.redirect_ack = ctrl_q.redirect_ack;
  assign bus.busy         = ctrl_q.busy;

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_redirects    <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (state_q == REDIRECT &&
          perf_redirects != 16'hFFFF) begin
        perf_redirects <= perf_redirects + 16'd1;
      end
      if (ctrl_q.stall &&
          perf_stall_cycles != 16'hFFFF) begin
        perf_stall_cycles <= perf_stall_cycles + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed vectors, queued expectations, monitor.
// Two DUTs share stimulus: HAZ_CYCLES=3 (dut3) and HAZ_CYCLES=1 (dut1).
module tb_fetch_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fetch_sequencer_if #(.PC_W(16)) bus3 ();
  fetch_sequencer_if #(.PC_W(16)) bus1 ();

`ifdef FETCH_PERF_EN
  logic [15:0] pr3, ps3, pr1, ps1;
`endif

  fetch_sequencer #(
    .PC_W(16), .HAZ_CYCLES(3), .FLUSH_CYCLES(2),
    .RESET_VECTOR(16'h0000)
  ) dut3 (
    .clk(clk), .reset(reset), .bus(bus3.master)
`ifdef FETCH_PERF_EN
    , .perf_redirects(pr3), .perf_stall_cycles(ps3)
`endif
  );

  fetch_sequencer #(
    .PC_W(16), .HAZ_CYCLES(1), .FLUSH_CYCLES(2),
    .RESET_VECTOR(16'h0000)
  ) dut1 (
    .clk(clk), .reset(reset), .bus(bus1.master)
`ifdef FETCH_PERF_EN
    , .perf_redirects(pr1), .perf_stall_cycles(ps1)
`endif
  );

  // {busy, redirect_ack, flush, stall_pm, stall, pc_mux_sel}
  localparam logic [5:0] C_RUN  = 6'b000000;
  localparam logic [5:0] C_BOOT = 6'b101001;
  localparam logic [5:0] C_RED  = 6'b111001;
  localparam logic [5:0] C_FL   = 6'b101000;
  localparam logic [5:0] C_ST   = 6'b100110;
  localparam logic [5:0] C_HL   = 6'b100110;

  logic [21:0] q3[$];
  logic [21:0] q1[$];
  logic [21:0] got3, got1, exp3, exp1;
  int n_chk = 0;
  int n_fail = 0;
  event chk_now;

  always begin
    @(negedge clk or chk_now);
    got3 = {bus3.busy, bus3.redirect_ack, bus3.flush,
            bus3.stall_pm, bus3.stall, bus3.pc_mux_sel,
            bus3.jmp_loc};
    got1 = {bus1.busy, bus1.redirect_ack, bus1.flush,
            bus1.stall_pm, bus1.stall, bus1.pc_mux_sel,
            bus1.jmp_loc};
    if (q3.size() > 0) begin
      exp3 = q3.pop_front();
      n_chk++;
      if (got3 !== exp3) begin
        n_fail++;
        $display("FAIL dut3_ctrl_jmp t=%0t got %h required %h",
                 $time, got3, exp3);
      end
    end
    if (q1.size() > 0) begin
      exp1 = q1.pop_front();
      n_chk++;
      if (got1 !== exp1) begin
        n_fail++;
        $display("FAIL dut1_ctrl_jmp t=%0t got %h required %h",
                 $time, got1, exp1);
      end
    end
  end

  task automatic drive(
    input logic br, input logic [15:0] t,
    input logic hz, input logic hl, input logic rs
  );
    bus3.branch_req = br;  bus1.branch_req = br;
    bus3.branch_target = t; bus1.branch_target = t;
    bus3.hazard_req = hz;  bus1.hazard_req = hz;
    bus3.halt_req = hl;    bus1.halt_req = hl;
    bus3.resume = rs;      bus1.resume = rs;
  endtask

  task automatic step(
    input logic r, input logic br, input logic [15:0] t,
    input logic hz, input logic hl, input logic rs,
    input logic [5:0] e3, input logic [5:0] e1,
    input logic [15:0] j
  );
    @(negedge clk);
    reset = r;
    drive(br, t, hz, hl, rs);
    @(posedge clk);
    #1;
    q3.push_back({e3, j});
    q1.push_back({e1, j});
  endtask

  // reset dropped between edges; checked before the next edge
  task automatic async_reset_mid();
    @(negedge clk);
    #1;
    reset = 1'b0;
    drive(0, 16'h0, 0, 0, 0);
    #1;
    q3.push_back({C_BOOT, 16'h0000});
    q1.push_back({C_BOOT, 16'h0000});
    ->chk_now;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(0, 16'h0, 0, 0, 0);
    // reset held, then boot and run
    step(0,0,16'h0,0,0,0, C_BOOT,C_BOOT, 16'h0000);
    step(0,0,16'h0,0,0,0, C_BOOT,C_BOOT, 16'h0000);
    step(1,0,16'h0,0,0,0, C_RUN, C_RUN,  16'h0000);
    step(1,0,16'h0,0,0,0, C_RUN, C_RUN,  16'h0000);
    // branch
    step(1,1,16'h0040,0,0,0, C_RED,C_RED, 16'h0040);
    step(1,0,16'h0,0,0,0, C_FL, C_FL,  16'h0040);
    step(1,0,16'h0,0,0,0, C_RUN,C_RUN, 16'h0040);
    // single hazard
    step(1,0,16'h0,1,0,0, C_ST, C_ST,  16'h0040);
    step(1,0,16'h0,0,0,0, C_ST, C_RUN, 16'h0040);
    step(1,0,16'h0,0,0,0, C_ST, C_RUN, 16'h0040);
    step(1,0,16'h0,0,0,0, C_RUN,C_RUN, 16'h0040);
    // repeated hazard does not extend
    step(1,0,16'h0,1,0,0, C_ST, C_ST,  16'h0040);
    step(1,0,16'h0,1,0,0, C_ST, C_RUN, 16'h0040);
    step(1,0,16'h0,0,0,0, C_ST, C_RUN, 16'h0040);
    step(1,0,16'h0,0,0,0, C_RUN,C_RUN, 16'h0040);
    // branch preempts hazard stall
    step(1,0,16'h0,1,0,0, C_ST, C_ST,  16'h0040);
    step(1,1,16'h0100,0,0,0, C_RED,C_RED, 16'h0100);
    step(1,0,16'h0,0,0,0, C_FL, C_FL,  16'h0100);
    step(1,0,16'h0,0,0,0, C_RUN,C_RUN, 16'h0100);
    // branch and hazard together
    step(1,1,16'h0200,1,0,0, C_RED,C_RED, 16'h0200);
    step(1,0,16'h0,0,0,0, C_FL, C_FL,  16'h0200);
    step(1,0,16'h0,0,0,0, C_RUN,C_RUN, 16'h0200);
    // retarget in REDIRECT and FLUSH; hazard ignored there
    step(1,1,16'h0300,0,0,0, C_RED,C_RED, 16'h0300);
    step(1,1,16'h0310,0,0,0, C_RED,C_RED, 16'h0310);
    step(1,0,16'h0,0,0,0, C_FL, C_FL,  16'h0310);
    step(1,1,16'h0320,0,0,0, C_RED,C_RED, 16'h0320);
    step(1,0,16'h0,1,0,0, C_FL, C_FL,  16'h0320);
    step(1,0,16'h0,1,0,0, C_RUN,C_RUN, 16'h0320);
    step(1,0,16'h0,0,0,0, C_RUN,C_RUN, 16'h0320);
    // halt for 5 cycles, resume beats halt_req
    for (int i = 0; i < 5; i++)
      step(1,0,16'h0,0,1,0, C_HL, C_HL, 16'h0320);
    step(1,0,16'h0,0,1,1, C_RUN,C_RUN, 16'h0320);
    step(1,0,16'h0,0,0,0, C_RUN,C_RUN, 16'h0320);
    // branch beats resume in HALT
    step(1,0,16'h0,0,1,0, C_HL, C_HL,  16'h0320);
    step(1,1,16'h0400,0,0,1, C_RED,C_RED, 16'h0400);
    step(1,0,16'h0,0,0,0, C_FL, C_FL,  16'h0400);
    step(1,0,16'h0,0,0,0, C_RUN,C_RUN, 16'h0400);
    // halt during HSTALL is taken on the first RUN cycle
    step(1,0,16'h0,1,0,0, C_ST, C_ST,  16'h0400);
    step(1,0,16'h0,0,1,0, C_ST, C_RUN, 16'h0400);
    step(1,0,16'h0,0,1,0, C_ST, C_HL,  16'h0400);
    step(1,0,16'h0,0,1,0, C_RUN,C_HL,  16'h0400);
    step(1,0,16'h0,0,1,0, C_HL, C_HL,  16'h0400);
    step(1,0,16'h0,0,0,1, C_RUN,C_RUN, 16'h0400);
    // async reset in FLUSH
    step(1,1,16'h0500,0,0,0, C_RED,C_RED, 16'h0500);
    step(1,0,16'h0,0,0,0, C_FL, C_FL,  16'h0500);
    async_reset_mid();
    step(0,0,16'h0,0,0,0, C_BOOT,C_BOOT, 16'h0000);
    step(1,0,16'h0,0,0,0, C_RUN, C_RUN,  16'h0000);
    step(1,0,16'h0,0,0,0, C_RUN, C_RUN,  16'h0000);
    @(negedge clk);
    #1;
    n_chk++;
    if (q3.size() != 0 || q1.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain left %0d/%0d required 0/0",
               q3.size(), q1.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
